// File: rtl/ncpu32k_cell_tdpram_aclkd_sclk_if.sv
// Two-port byte-masked RAM access bundle: port A and port B request fields plus registered read data.
interface ncpu32k_cell_tdpram_aclkd_sclk_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic              en_a;
    logic [AW-1:0]     addr_a;
    logic [DW/8-1:0]   we_a;
    logic [DW-1:0]     din_a;
    logic [DW-1:0]     dout_a;

    logic              en_b;
    logic [AW-1:0]     addr_b;
    logic [DW/8-1:0]   we_b;
    logic [DW-1:0]     din_b;
    logic [DW-1:0]     dout_b;

    modport master (
        output en_a, addr_a, we_a, din_a,
        output en_b, addr_b, we_b, din_b,
        input  dout_a, dout_b
    );

    modport slave (
        input  en_a, addr_a, we_a, din_a,
        input  en_b, addr_b, we_b, din_b,
        output dout_a, dout_b
    );
endinterface

// File: rtl/ncpu32k_cell_tdpram_aclkd_sclk.sv
// True dual-port byte-masked RAM on one clock, read-first, port B wins per-lane write collisions.
// Latency: 1 cycle read data; no backpressure, every enabled access completes on the edge.
module ncpu32k_cell_tdpram_aclkd_sclk #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic clk,
    input  logic rst,
    ncpu32k_cell_tdpram_aclkd_sclk_if.slave bus
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Reads sample mem before this edge's NBA updates land, giving read-first on both ports.
    // Port B lanes are assigned after port A so B's value is the one that sticks on overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout_a <= '0;
            bus.dout_b <= '0;
        end else begin
            if (bus.en_a) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.we_a[i]) begin
                        mem[bus.addr_a][8*i +: 8] <= bus.din_a[8*i +: 8];
                    end
                end
                bus.dout_a <= mem[bus.addr_a];
            end
            if (bus.en_b) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.we_b[i]) begin
                        mem[bus.addr_b][8*i +: 8] <= bus.din_b[8*i +: 8];
                    end
                end
                bus.dout_b <= mem[bus.addr_b];
            end
        end
    end
endmodule

// File: tb/tb_ncpu32k_cell_tdpram_aclkd_sclk.sv
// Directed bench for the dual-port RAM: reset, byte masks, read-first, collisions, gating, boundaries.
module tb_ncpu32k_cell_tdpram_aclkd_sclk;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ncpu32k_cell_tdpram_aclkd_sclk_if #(.AW(AW), .DW(DW)) bus ();

    ncpu32k_cell_tdpram_aclkd_sclk #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.en_a = 1'b0; bus.addr_a = '0; bus.we_a = '0; bus.din_a = '0;
        bus.en_b = 1'b0; bus.addr_b = '0; bus.we_b = '0; bus.din_b = '0;
    endtask

    task automatic acc_a(input logic [AW-1:0] addr, input logic [3:0] we, input logic [DW-1:0] din);
        bus.en_a = 1'b1; bus.addr_a = addr; bus.we_a = we; bus.din_a = din;
    endtask

    task automatic acc_b(input logic [AW-1:0] addr, input logic [3:0] we, input logic [DW-1:0] din);
        bus.en_b = 1'b1; bus.addr_b = addr; bus.we_b = we; bus.din_b = din;
    endtask

    // Inputs change 1 time unit after the edge; outputs of that edge are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        check_eq("rst_dout_a", bus.dout_a, 32'h0);
        check_eq("rst_dout_b", bus.dout_b, 32'h0);
        rst = 1'b0;

        // Byte-lane masking
        idle(); acc_a(8'd5, 4'hF, 32'h11223344); step();
        idle(); acc_a(8'd5, 4'b0101, 32'hAABBCCDD); step();
        check_eq("mask_readfirst_a", bus.dout_a, 32'h11223344);
        idle(); acc_b(8'd5, 4'h0, 32'h0); step();
        check_eq("mask_merge_b", bus.dout_b, 32'h11BB33DD);

        // Read-first on same and other port
        idle(); acc_a(8'd7, 4'hF, 32'h0); step();
        idle(); acc_a(8'd7, 4'hF, 32'hDEADBEEF); acc_b(8'd7, 4'h0, 32'h0); step();
        check_eq("rf_other_port", bus.dout_b, 32'h0);
        check_eq("rf_same_port", bus.dout_a, 32'h0);
        idle(); acc_b(8'd7, 4'h0, 32'h0); step();
        check_eq("rf_after", bus.dout_b, 32'hDEADBEEF);

        // Same-address collisions
        idle(); acc_a(8'd3, 4'hF, 32'h11111111); acc_b(8'd3, 4'hF, 32'h22222222); step();
        idle(); acc_a(8'd3, 4'h0, 32'h0); step();
        check_eq("coll_full", bus.dout_a, 32'h22222222);
        idle(); acc_a(8'd3, 4'hF, 32'h11111111); acc_b(8'd3, 4'b0011, 32'h22222222); step();
        idle(); acc_b(8'd3, 4'h0, 32'h0); step();
        check_eq("coll_lane", bus.dout_b, 32'h11112222);

        // Enable gating
        idle(); acc_a(8'd9, 4'hF, 32'h12345678); step();
        idle(); acc_a(8'd9, 4'h0, 32'h0); step();
        check_eq("gate_pre", bus.dout_a, 32'h12345678);
        idle(); bus.addr_a = 8'd3; bus.we_a = 4'hF; bus.din_a = 32'hFFFFFFFF; step();
        check_eq("gate_hold", bus.dout_a, 32'h12345678);
        idle(); bus.addr_a = 8'd9; bus.we_a = 4'hF; bus.din_a = 32'hFFFFFFFF; step();
        check_eq("gate_hold2", bus.dout_a, 32'h12345678);
        idle(); acc_b(8'd9, 4'h0, 32'h0); step();
        check_eq("gate_mem", bus.dout_b, 32'h12345678);

        // Boundary addresses with parallel traffic
        idle(); acc_a(8'd0, 4'hF, 32'hA0A0A0A0); acc_b(8'd255, 4'hF, 32'hB0B0B0B0); step();
        idle(); acc_a(8'd255, 4'h0, 32'h0); acc_b(8'd0, 4'h0, 32'h0); step();
        check_eq("bound_a_top", bus.dout_a, 32'hB0B0B0B0);
        check_eq("bound_b_zero", bus.dout_b, 32'hA0A0A0A0);
        idle(); acc_a(8'd0, 4'h0, 32'h0); acc_b(8'd127, 4'h0, 32'h0); step();
        check_eq("pure_read", bus.dout_a, 32'hA0A0A0A0);
        idle(); acc_a(8'd255, 4'h0, 32'h0); step();
        check_eq("pure_read_top", bus.dout_a, 32'hB0B0B0B0);

        // Reset clears outputs, blocks writes, keeps array
        idle(); acc_b(8'd0, 4'h0, 32'h0); step();
        rst = 1'b1;
        idle(); acc_a(8'd5, 4'hF, 32'h0); acc_b(8'd0, 4'hF, 32'h0);
        step();
        step();
        check_eq("rst2_dout_a", bus.dout_a, 32'h0);
        check_eq("rst2_dout_b", bus.dout_b, 32'h0);
        rst = 1'b0;
        idle(); acc_a(8'd5, 4'h0, 32'h0); acc_b(8'd0, 4'h0, 32'h0); step();
        check_eq("post_rst_a", bus.dout_a, 32'h11BB33DD);
        check_eq("post_rst_b", bus.dout_b, 32'hA0A0A0A0);
        idle(); step();
        check_eq("idle_hold_a", bus.dout_a, 32'h11BB33DD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ncpu32k_cell_tdpram_aclkd_sclk.md
NCPU32K_CELL_TDPRAM_ACLKD_SCLK -- requirements
Module: ncpu32k_cell_tdpram_aclkd_sclk

Interface
REQ-001 Parameter AW, default 8: address width; depth SHALL be 2^AW words.
REQ-002 Parameter DW, default 32: data width; SHALL be a multiple of 8.
REQ-003 Port clk, input, 1: single clock for both ports; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port en_a, input, 1: port A access enable.
REQ-006 Port addr_a, input, AW: port A word address.
REQ-007 Port we_a, input, DW/8: port A byte-lane write mask; bit i covers din_a[8i+7:8i].
REQ-008 Port din_a, input, DW: port A write data.
REQ-009 Port dout_a, output, DW: port A registered read data.
REQ-010 Ports en_b, addr_b, we_b, din_b, dout_b: identical to REQ-005..REQ-009, for port B.

Function
REQ-011 Both ports SHALL be fully independent read/write ports on one shared 2^AW x DW array.
REQ-012 Port X with en_x=1 SHALL, on the rising edge, write each byte lane i with we_x[i]=1 from din_x into mem[addr_x]; lanes with we_x[i]=0 SHALL keep their contents.
REQ-013 Port X with en_x=1 SHALL load dout_x with mem[addr_x] regardless of we_x; read latency SHALL be 1 cycle (data valid after the edge that samples addr_x).
REQ-014 Read mode SHALL be read-first: on a same-cycle write to the address being read (same or other port), dout SHALL return the pre-write contents.
REQ-015 Port X with en_x=0 SHALL perform no write, even when we_x is nonzero, and dout_x SHALL hold its previous value.
REQ-016 A read with we_x all-zero SHALL be a pure read with no side effects.
REQ-017 Simultaneous writes from both ports to the same address SHALL resolve per byte lane: a lane written by both ports SHALL take port B's data; a lane written by only one port SHALL take that port's data.
REQ-018 Writes to different addresses in the same cycle SHALL both complete.
REQ-019 Addresses SHALL be fully decoded with no aliasing; address 2^AW-1 SHALL be valid storage.
REQ-020 There SHALL be no combinational path from any input to dout_a or dout_b.
REQ-021 Uninitialized array contents SHALL be don't-care; the bench SHALL write before reading.

Reset
REQ-022 While rst=1, dout_a and dout_b SHALL be cleared to 0 on the clock edge, and writes SHALL be suppressed.
REQ-023 rst SHALL NOT clear array contents; data written before reset SHALL be readable after reset deasserts.
REQ-024 The first rising edge with rst=0 SHALL accept accesses normally; there is no extra recovery latency.

Verification
REQ-025 Reset: assert rst for 2 cycles after both outputs have held nonzero data -> dout_a=dout_b=0; then read a previously written address -> the original data returns.
REQ-026 Byte mask: A writes 0x11223344 to addr 5 with we_a=4'hF, then 0xAABBCCDD with we_a=4'b0101; B reads addr 5 -> dout_b=0x11BB33DD one cycle later.
REQ-027 Read-first: mem[7]=0x0; A writes 0xDEADBEEF to addr 7 while B reads addr 7 in the same cycle -> dout_b=0x00000000; next B read -> 0xDEADBEEF.
REQ-028 Collision: A writes 0x11111111 and B writes 0x22222222 to addr 3, both with mask 4'hF, in the same cycle -> a subsequent read gives 0x22222222. With we_a=4'hF and we_b=4'b0011 -> 0x11112222.
REQ-029 Enable gating: en_a=0 with we_a=4'hF and din_a=0xFFFFFFFF at addr 9 holding 0x12345678 -> mem unchanged and dout_a holds its prior value.
REQ-030 Boundary and parallel traffic: A writes addr 0 while B writes addr 2^AW-1 in the same cycle, then the ports cross-read -> each port returns the other's data with no aliasing.
